// File: rtl/bar_pkg.sv
// Shared types and helpers for the bar-height frame loader.
package bar_pkg;

    typedef enum logic [1:0] {StIdle, StRead, StCommit} loader_state_t;

    localparam int unsigned DEF_NUM_BARS   = 20;
    localparam int unsigned DEF_HEIGHT_W   = 6;
    localparam int unsigned DEF_RD_LATENCY = 3;

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : 0;
    endfunction

endpackage

// File: rtl/peak_tracker.sv
// Per-bar peak marker with hold timer and linear decay, updated on each frame commit.
module peak_tracker import bar_pkg::*; #(
    parameter int unsigned HEIGHT_W    = DEF_HEIGHT_W,
    parameter int unsigned HOLD_FRAMES = 8,
    parameter int unsigned DECAY_STEP  = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                commit_i,
    input  logic [HEIGHT_W-1:0] h_i,
    input  logic                peak_enable_i,
    output logic [HEIGHT_W-1:0] peak_o
);

    localparam int unsigned HoldW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    logic [HEIGHT_W-1:0] peak_q, peak_d, decayed;
    logic [HoldW-1:0]    hold_q, hold_d;

    always_comb begin
        peak_d  = peak_q;
        hold_d  = hold_q;
        decayed = HEIGHT_W'(sat_sub(32'(peak_q), DECAY_STEP));
        if (commit_i) begin
            if (!peak_enable_i) begin
                peak_d = h_i;
                hold_d = '0;
            end else if (h_i >= peak_q) begin
                peak_d = h_i;
                hold_d = HoldW'(HOLD_FRAMES);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HoldW'(1);
            end else begin
                peak_d = (h_i > decayed) ? h_i : decayed;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            peak_q <= '0;
            hold_q <= '0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end

    assign peak_o = peak_q;

endmodule

// File: rtl/bar_frame_loader.sv
// Bursts NUM_BARS heights out of the VGA RAM into a shadow buffer, then commits them
// (with peak markers) to the display in a single cycle.
module bar_frame_loader import bar_pkg::*; #(
    parameter int unsigned NUM_BARS    = DEF_NUM_BARS,
    parameter int unsigned HEIGHT_W    = DEF_HEIGHT_W,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY,
    parameter int unsigned HOLD_FRAMES = 8,
    parameter int unsigned DECAY_STEP  = 1
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_n,
    input  logic                         frame_ready,
    input  logic                         peak_enable,
    output logic [ADDR_W-1:0]            ram_rdaddress,
    input  logic [HEIGHT_W-1:0]          ram_q,
    output logic [NUM_BARS*HEIGHT_W-1:0] heights,
    output logic [NUM_BARS*HEIGHT_W-1:0] peaks,
    output logic                         frame_valid,
    output logic                         busy,
    output logic [7:0]                   overrun_cnt
);

    localparam int unsigned IdxW = $clog2(NUM_BARS + 1);
    localparam int unsigned SelW = $clog2(NUM_BARS);

    loader_state_t         state_q, state_d;
    logic                  fr_q;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;
    logic                  frame_valid_q, frame_valid_d;
    logic [7:0]            overrun_q, overrun_d;
    logic [ADDR_W-1:0]     rdaddr_q, rdaddr_d;
    logic                  addr_vld_q, addr_vld_d;
    logic [RD_LATENCY-1:0] vpipe_q, vpipe_d;
    logic [IdxW-1:0]       issue_idx_q, issue_idx_d;
    logic [IdxW-1:0]       cap_idx_q, cap_idx_d;
    logic [HEIGHT_W-1:0]   shadow_q [NUM_BARS];
    logic [HEIGHT_W-1:0]   heights_q [NUM_BARS];
    logic                  req, capture, commit;

    assign req     = frame_ready & ~fr_q;
    // Capture is driven purely by the latency pipe tail, never by ram_q itself.
    assign capture = (state_q == StRead) & vpipe_q[RD_LATENCY-1];

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        busy_d        = busy_q;
        frame_valid_d = 1'b0;
        overrun_d     = overrun_q;
        rdaddr_d      = rdaddr_q;
        addr_vld_d    = 1'b0;
        vpipe_d       = RD_LATENCY'({vpipe_q, addr_vld_q});
        issue_idx_d   = issue_idx_q;
        cap_idx_d     = cap_idx_q;
        commit        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req || pending_q) begin
                    state_d     = StRead;
                    busy_d      = 1'b1;
                    pending_d   = req & pending_q;
                    issue_idx_d = '0;
                    cap_idx_d   = '0;
                    vpipe_d     = '0;
                end
            end
            StRead: begin
                if (issue_idx_q < IdxW'(NUM_BARS)) begin
                    rdaddr_d    = ADDR_W'(BASE_ADDR + 32'(issue_idx_q));
                    issue_idx_d = issue_idx_q + IdxW'(1);
                    addr_vld_d  = 1'b1;
                end
                if (capture) begin
                    cap_idx_d = cap_idx_q + IdxW'(1);
                    if (cap_idx_q == IdxW'(NUM_BARS - 1)) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                commit        = 1'b1;
                frame_valid_d = 1'b1;
                if (pending_q) begin
                    state_d     = StRead;
                    busy_d      = 1'b1;
                    pending_d   = 1'b0;
                    issue_idx_d = '0;
                    cap_idx_d   = '0;
                    vpipe_d     = '0;
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Requests arriving during a load queue one deep; anything beyond that is counted.
        if (state_q != StIdle && req) begin
            if (pending_q) begin
                if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            fr_q          <= 1'b1;
            pending_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            overrun_q     <= '0;
            rdaddr_q      <= '0;
            addr_vld_q    <= 1'b0;
            vpipe_q       <= '0;
            issue_idx_q   <= '0;
            cap_idx_q     <= '0;
            for (int i = 0; i < NUM_BARS; i++) heights_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            fr_q          <= frame_ready;
            pending_q     <= pending_d;
            busy_q        <= busy_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            rdaddr_q      <= rdaddr_d;
            addr_vld_q    <= addr_vld_d;
            vpipe_q       <= vpipe_d;
            issue_idx_q   <= issue_idx_d;
            cap_idx_q     <= cap_idx_d;
            if (commit) begin
                for (int i = 0; i < NUM_BARS; i++) heights_q[i] <= shadow_q[i];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (capture) shadow_q[cap_idx_q[SelW-1:0]] <= ram_q;
    end

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        assign heights[g*HEIGHT_W +: HEIGHT_W] = heights_q[g];

        peak_tracker #(
            .HEIGHT_W   (HEIGHT_W),
            .HOLD_FRAMES(HOLD_FRAMES),
            .DECAY_STEP (DECAY_STEP)
        ) u_peak (
            .clk_i        (CLOCK_50),
            .rst_ni       (reset_n),
            .commit_i     (commit),
            .h_i          (shadow_q[g]),
            .peak_enable_i(peak_enable),
            .peak_o       (peaks[g*HEIGHT_W +: HEIGHT_W])
        );
    end

    assign ram_rdaddress = rdaddr_q;
    assign frame_valid   = frame_valid_q;
    assign busy          = busy_q;
    assign overrun_cnt   = overrun_q;

endmodule

// File: tb/tb_bar_frame_loader.sv
// Directed bench: three loader instances (default, latency 1 / short hold, wrapping base).
module tb_bar_frame_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (20 bars, latency 3)
    logic         rst_a = 1'b0, fr_a = 1'b0, pe_a = 1'b0;
    logic [5:0]   addr_a, q_a;
    logic [119:0] heights_a, peaks_a;
    logic         fv_a, busy_a;
    logic [7:0]   ov_a;
    logic [5:0]   mem_a [64];
    logic [5:0]   pa [3];

    // Instance B: latency 1, hold 2 frames
    logic         rst_b = 1'b0, fr_b = 1'b0, pe_b = 1'b0;
    logic [5:0]   addr_b, q_b;
    logic [119:0] heights_b, peaks_b;
    logic         fv_b, busy_b;
    logic [7:0]   ov_b;
    logic [5:0]   mem_b [64];
    logic [5:0]   pb;

    // Instance C: 8 bars starting at address 60
    logic         rst_c = 1'b0, fr_c = 1'b0, pe_c = 1'b0;
    logic [5:0]   addr_c, q_c;
    logic [47:0]  heights_c, peaks_c;
    logic         fv_c, busy_c;
    logic [7:0]   ov_c;
    logic [5:0]   mem_c [64];
    logic [5:0]   pc [3];

    always @(posedge clk) begin
        pa[0] <= addr_a; pa[1] <= pa[0]; pa[2] <= pa[1];
        pb    <= addr_b;
        pc[0] <= addr_c; pc[1] <= pc[0]; pc[2] <= pc[1];
    end
    assign q_a = mem_a[pa[2]];
    assign q_b = mem_b[pb];
    assign q_c = mem_c[pc[2]];

    bar_frame_loader u_dut_a (
        .CLOCK_50(clk), .reset_n(rst_a), .frame_ready(fr_a), .peak_enable(pe_a),
        .ram_rdaddress(addr_a), .ram_q(q_a), .heights(heights_a), .peaks(peaks_a),
        .frame_valid(fv_a), .busy(busy_a), .overrun_cnt(ov_a)
    );

    bar_frame_loader #(.RD_LATENCY(1), .HOLD_FRAMES(2)) u_dut_b (
        .CLOCK_50(clk), .reset_n(rst_b), .frame_ready(fr_b), .peak_enable(pe_b),
        .ram_rdaddress(addr_b), .ram_q(q_b), .heights(heights_b), .peaks(peaks_b),
        .frame_valid(fv_b), .busy(busy_b), .overrun_cnt(ov_b)
    );

    bar_frame_loader #(.NUM_BARS(8), .BASE_ADDR(60)) u_dut_c (
        .CLOCK_50(clk), .reset_n(rst_c), .frame_ready(fr_c), .peak_enable(pe_c),
        .ram_rdaddress(addr_c), .ram_q(q_c), .heights(heights_c), .peaks(peaks_c),
        .frame_valid(fv_c), .busy(busy_c), .overrun_cnt(ov_c)
    );

    int           sel = 0;
    logic         fv_s, busy_s;
    logic [5:0]   addr_s;
    logic [7:0]   ov_s;
    logic [119:0] heights_s, peaks_s;

    always_comb begin
        fv_s = 1'b0; busy_s = 1'b0; addr_s = '0; ov_s = '0; heights_s = '0; peaks_s = '0;
        case (sel)
            0: begin
                fv_s = fv_a; busy_s = busy_a; addr_s = addr_a; ov_s = ov_a;
                heights_s = heights_a; peaks_s = peaks_a;
            end
            1: begin
                fv_s = fv_b; busy_s = busy_b; addr_s = addr_b; ov_s = ov_b;
                heights_s = heights_b; peaks_s = peaks_b;
            end
            default: begin
                fv_s = fv_c; busy_s = busy_c; addr_s = addr_c; ov_s = ov_c;
                heights_s[47:0] = heights_c; peaks_s[47:0] = peaks_c;
            end
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_fr(input logic v);
        case (sel)
            0:       fr_a = v;
            1:       fr_b = v;
            default: fr_c = v;
        endcase
    endtask

    // One frame_ready pulse; checks the address sequence, commit latency and pulse width.
    task automatic load_frame(input int nb, input int lat, input int base);
        int edges;
        bit seen;
        edges = 0;
        seen  = 0;
        @(negedge clk); set_fr(1'b1);
        @(posedge clk);
        while (!seen && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (edges <= nb) check($sformatf("addr[%0d]", edges - 1), int'(addr_s),
                                   (base + edges - 1) % 64);
            if (fv_s) seen = 1;
        end
        check("frame_valid latency", edges, nb + lat + 2);
        @(posedge clk); #1;
        check("frame_valid one cycle", int'(fv_s), 0);
        check("busy after commit", int'(busy_s), 0);
        @(negedge clk); set_fr(1'b0);
    endtask

    task automatic check_bars(input int nb, input int off, input bit chk_peaks);
        for (int i = 0; i < nb; i++) begin
            check($sformatf("height[%0d]", i), int'(heights_s[i*6 +: 6]), i + off);
            if (chk_peaks) check($sformatf("peak[%0d]", i), int'(peaks_s[i*6 +: 6]), i + off);
        end
    endtask

    typedef struct {
        logic pe;
        int   h0, h1;
        int   p0, p1;
    } peak_vec_t;

    peak_vec_t pvec [7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, first_edge, second_edge, active;
        bit chk_addr;

        pvec[0] = '{1'b1, 40, 5, 40, 5};
        pvec[1] = '{1'b1, 10, 7, 40, 7};
        pvec[2] = '{1'b1, 10, 3, 40, 7};
        pvec[3] = '{1'b1, 10, 3, 39, 7};
        pvec[4] = '{1'b1, 10, 3, 38, 6};
        pvec[5] = '{1'b1, 10, 3, 37, 5};
        pvec[6] = '{1'b0, 10, 3, 10, 3};

        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 6'(i + 1);
            mem_b[i] = 6'(i + 1);
            mem_c[i] = '0;
        end
        for (int i = 0; i < 8; i++) mem_c[(60 + i) % 64] = 6'(i + 9);

        repeat (3) @(posedge clk);
        @(negedge clk); rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        @(posedge clk); #1;

        // Reset state
        sel = 0;
        check("reset heights", int'(heights_a != '0), 0);
        check("reset peaks", int'(peaks_a != '0), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset frame_valid", int'(fv_a), 0);
        check("reset overrun", int'(ov_a), 0);
        check("reset rdaddress", int'(addr_a), 0);

        // Basic frame at latency 3
        load_frame(20, 3, 0);
        check_bars(20, 1, 1'b1);

        // Three requests during one load: one queued, one dropped
        @(negedge clk); fr_a = 1'b1;
        @(posedge clk);
        @(negedge clk); fr_a = 1'b0;
        repeat (3) @(negedge clk);
        fr_a = 1'b1;
        @(negedge clk); fr_a = 1'b0;
        repeat (2) @(negedge clk);
        fr_a = 1'b1;
        @(negedge clk); fr_a = 1'b0;
        pulses = 0; chk_addr = 0; first_edge = 0; second_edge = 0;
        for (int e = 1; e <= 120; e++) begin
            @(posedge clk); #1;
            if (chk_addr) begin
                check("second load first addr", int'(addr_a), 0);
                chk_addr = 0;
            end
            if (fv_a) begin
                pulses++;
                if (pulses == 1) begin
                    first_edge = e;
                    check("busy through back-to-back commit", int'(busy_a), 1);
                    chk_addr = 1;
                end else if (pulses == 2) begin
                    second_edge = e;
                end
            end
        end
        check("frame_valid pulses", pulses, 2);
        check("back-to-back spacing", second_edge - first_edge, 25);
        check("overrun count", int'(ov_a), 1);
        check_bars(20, 1, 1'b0);

        // Reset mid-READ with frame_ready held high
        @(negedge clk); fr_a = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        @(negedge clk); rst_a = 1'b0;
        @(posedge clk); #1;
        check("midreset heights", int'(heights_a != '0), 0);
        check("midreset peaks", int'(peaks_a != '0), 0);
        check("midreset busy", int'(busy_a), 0);
        check("midreset frame_valid", int'(fv_a), 0);
        check("midreset overrun", int'(ov_a), 0);
        check("midreset rdaddress", int'(addr_a), 0);
        @(negedge clk); rst_a = 1'b1;
        active = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy_a || fv_a) active++;
        end
        check("no load while level held", active, 0);
        @(negedge clk); fr_a = 1'b0;
        load_frame(20, 3, 0);
        check_bars(20, 1, 1'b1);

        // Latency 1 instance: same data, shorter commit latency
        sel = 1;
        load_frame(20, 1, 0);
        check_bars(20, 1, 1'b1);

        // Peak hold and decay on bars 0 and 1
        foreach (pvec[k]) begin
            mem_b[0] = 6'(pvec[k].h0);
            mem_b[1] = 6'(pvec[k].h1);
            pe_b     = pvec[k].pe;
            load_frame(20, 1, 0);
            check($sformatf("vec%0d height0", k), int'(heights_b[5:0]), pvec[k].h0);
            check($sformatf("vec%0d peak0", k), int'(peaks_b[5:0]), pvec[k].p0);
            check($sformatf("vec%0d peak1", k), int'(peaks_b[11:6]), pvec[k].p1);
        end

        // Address wrap: 60..63 then 0..3
        sel = 2;
        load_frame(8, 3, 60);
        check_bars(8, 9, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
